// File: rtl/crg_triple_sink_if.sv
// Host request, CRG run/stream and downstream triple handshake bundled for crg_triple_sink.
// slave is the sink's view; master is the view of whatever drives it.
interface crg_triple_sink_if #(
   parameter int DATA_W = 256,
   parameter int CNT_W  = 32
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic [CNT_W-1:0]  req_count_i;
   logic [CNT_W-1:0]  req_base_i;
   logic              run_o;
   logic [CNT_W-1:0]  cnt_start_o;
   logic [CNT_W-1:0]  cnt_end_o;
   logic              dvld_i;
   logic [DATA_W-1:0] a_i;
   logic [DATA_W-1:0] b_i;
   logic [DATA_W-1:0] c_i;
   logic [7:0]        e_i;
   logic              tri_valid_o;
   logic              tri_ready_i;
   logic [DATA_W-1:0] tri_a_o;
   logic [DATA_W-1:0] tri_b_o;
   logic [DATA_W-1:0] tri_c_o;
   logic [7:0]        tri_e_o;
   logic              done_o;
   logic              err_ovf_o;

   modport slave (
      input  req_valid_i, req_count_i, req_base_i, dvld_i, a_i, b_i, c_i, e_i, tri_ready_i,
      output req_ready_o, run_o, cnt_start_o, cnt_end_o, tri_valid_o,
             tri_a_o, tri_b_o, tri_c_o, tri_e_o, done_o, err_ovf_o
   );

   modport master (
      output req_valid_i, req_count_i, req_base_i, dvld_i, a_i, b_i, c_i, e_i, tri_ready_i,
      input  req_ready_o, run_o, cnt_start_o, cnt_end_o, tri_valid_o,
             tri_a_o, tri_b_o, tri_c_o, tri_e_o, done_o, err_ovf_o
   );
endinterface

// File: rtl/crg_triple_sink.sv
// Drives the CRG in credit-limited bursts for a K-triple request and buffers its
// unthrottled output stream in a FIFO delivered over valid/ready.
module crg_triple_sink #(
   parameter int DATA_W    = 256,
   parameter int CNT_W     = 32,
   parameter int DEPTH     = 64,
   parameter int MAX_BURST = 32
) (
   input logic              clk_i,
   input logic              rst_n_i,
   crg_triple_sink_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 3 * DATA_W + 8;

   typedef enum logic [2:0] {S_IDLE, S_PLAN, S_ISSUE, S_GAP, S_DRAIN} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  k_q, remaining_q, next_q, delivered_q;
   logic [CNT_W-1:0]  burst_q, start_q, end_q, gap_q;
   logic [CW-1:0]     fcnt_q, fcnt_d, out_q, out_d, out_add;
   logic [AW-1:0]     wr_q, rd_q;
   logic              err_q, zdone_q;
   logic [EW-1:0]     mem [DEPTH];
   logic [EW-1:0]     head;

   logic              full, empty, pop, push, accept, last_pop, drain_ok;
   logic [CW:0]       used;
   logic [CNT_W-1:0]  credit, room, n_plan, next_sum, next_after;

   assign full     = (fcnt_q == CW'(DEPTH));
   assign empty    = (fcnt_q == '0);
   assign pop      = !empty && bus.tri_ready_i;
   assign push     = bus.dvld_i && (!full || pop);
   assign accept   = bus.req_valid_i && (state_q == S_IDLE);
   assign last_pop = pop && (state_q != S_IDLE) && ((delivered_q + CNT_W'(1)) == k_q);
   assign drain_ok = (out_q == '0) && (delivered_q == k_q);

   assign used     = {1'b0, fcnt_q} + {1'b0, out_q};
   assign credit   = (used >= (CW+1)'(DEPTH)) ? '0 : CNT_W'((CW+1)'(DEPTH) - used);
   // next_q is never 0, so 2^CNT_W - next_q is the room left before the counter wraps
   assign room     = '0 - next_q;
   assign next_sum = next_q + burst_q;
   assign next_after = (next_sum == '0) ? CNT_W'(1) : next_sum;

   always_comb begin
      n_plan = remaining_q;
      if (n_plan > CNT_W'(MAX_BURST)) n_plan = CNT_W'(MAX_BURST);
      if (n_plan > credit)             n_plan = credit;
      if (n_plan > room)               n_plan = room;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept && (bus.req_count_i != '0)) state_d = S_PLAN;
         S_PLAN:  if (n_plan != '0) state_d = S_ISSUE;
         S_ISSUE: state_d = S_GAP;
         S_GAP:   if (gap_q == '0) state_d = (remaining_q != '0) ? S_PLAN : S_DRAIN;
         // the last pop may already have happened during GAP when the CRG latency is short
         S_DRAIN: if (last_pop || drain_ok) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.run_o       = (state_q == S_ISSUE);
      bus.req_ready_o = (state_q == S_IDLE);
      bus.done_o      = zdone_q || last_pop;
   end

   always_comb begin
      out_add = out_q + ((state_q == S_ISSUE) ? CW'(burst_q) : '0);
      out_d   = out_add;
      if (bus.dvld_i && (out_add != '0)) out_d = out_add - CW'(1);
   end

   always_comb begin
      unique case ({push, pop})
         2'b10:   fcnt_d = fcnt_q + CW'(1);
         2'b01:   fcnt_d = fcnt_q - CW'(1);
         default: fcnt_d = fcnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         k_q         <= '0;
         remaining_q <= '0;
         next_q      <= '0;
         delivered_q <= '0;
         burst_q     <= '0;
         start_q     <= '0;
         end_q       <= '0;
         gap_q       <= '0;
         fcnt_q      <= '0;
         out_q       <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         err_q       <= 1'b0;
         zdone_q     <= 1'b0;
      end else begin
         zdone_q <= accept && (bus.req_count_i == '0);
         if (accept) begin
            k_q         <= bus.req_count_i;
            remaining_q <= bus.req_count_i;
            next_q      <= (bus.req_base_i == '0) ? CNT_W'(1) : bus.req_base_i;
            delivered_q <= '0;
         end else if (pop) begin
            delivered_q <= delivered_q + CNT_W'(1);
         end
         if ((state_q == S_PLAN) && (n_plan != '0)) begin
            burst_q <= n_plan;
            start_q <= next_q;
            end_q   <= next_q + n_plan - CNT_W'(1);
         end
         if (state_q == S_ISSUE) begin
            remaining_q <= remaining_q - burst_q;
            next_q      <= next_after;
            gap_q       <= burst_q + CNT_W'(1);
         end else if ((state_q == S_GAP) && (gap_q != '0)) begin
            gap_q <= gap_q - CNT_W'(1);
         end
         out_q  <= out_d;
         fcnt_q <= fcnt_d;
         if (push) wr_q <= wr_q + AW'(1);
         if (pop)  rd_q <= rd_q + AW'(1);
         if (bus.dvld_i && full && !pop) err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_q] <= {bus.e_i, bus.c_i, bus.b_i, bus.a_i};
   end

   assign head            = empty ? '0 : mem[rd_q];
   assign bus.tri_valid_o = !empty;
   assign bus.tri_a_o     = head[DATA_W-1:0];
   assign bus.tri_b_o     = head[2*DATA_W-1:DATA_W];
   assign bus.tri_c_o     = head[3*DATA_W-1:2*DATA_W];
   assign bus.tri_e_o     = head[EW-1:3*DATA_W];
   assign bus.cnt_start_o = start_q;
   assign bus.cnt_end_o   = end_q;
   assign bus.err_ovf_o   = err_q;
endmodule

// File: doc/crg_triple_sink.md
Name: crg_triple_sink

Overview:
- Consumer and initiator for the correlated random generator (CRG).
- Takes a host request for K Beaver triples and drives the CRG run/cnt_start/cnt_end interface in credit-limited bursts.
- Captures the CRG's unthrottled dvld/a/b/c/e stream into an internal FIFO.
- Delivers triples downstream over a valid/ready handshake, so the CRG output can never overrun a stalled consumer.

Parameters:
- DATA_W, 256, width of each of a/b/c.
- CNT_W, 32, CRG plaintext counter width.
- DEPTH, 64, FIFO depth in triples (power of 2, >= 4).
- MAX_BURST, 32, maximum triples per CRG run (<= DEPTH).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  host request valid.
- req_ready_o  out  1  high only in IDLE.
- req_count_i  in  CNT_W  number of triples K (K=0 accepted, completes immediately).
- req_base_i  in  CNT_W  first counter value (0 treated as 1).
- run_o  out  1  one-cycle start pulse to CRG.
- cnt_start_o  out  CNT_W  burst first counter.
- cnt_end_o  out  CNT_W  burst last counter.
- dvld_i  in  1  CRG data valid.
- a_i, b_i, c_i  in  DATA_W each  CRG triple.
- e_i  in  8  CRG e share.
- tri_valid_o  out  1  FIFO non-empty.
- tri_ready_i  in  1  downstream accept.
- tri_a_o, tri_b_o, tri_c_o  out  DATA_W each  FIFO head.
- tri_e_o  out  8  FIFO head.
- done_o  out  1  one-cycle pulse when the last triple of a request is popped.
- err_ovf_o  out  1  sticky; set on dvld_i while FIFO full.

Behaviour:
- Reset (async assert, synchronous release): state IDLE; FIFO empty; all counters 0.
  - Outputs at reset: run_o=0, cnt_start_o=0, cnt_end_o=0, tri_valid_o=0, done_o=0, err_ovf_o=0, req_ready_o=1; tri_* data 0.
  - Reset mid-burst discards in-flight data accounting. The bench resets CRG and sink together.
- CRG contract:
  - Counter value 0 means idle.
  - A burst S..E yields E-S+1 dvld beats, in counter order, a fixed latency later.
  - run must not be reasserted until the CRG counter has returned to 0, i.e. at least E-S+2 cycles after the previous run.
- Credits:
  - credit = DEPTH - fifo_count - outstanding.
  - outstanding += N when run_o issues; outstanding -= 1 per dvld_i.
  - A push and a pop in the same cycle leave fifo_count unchanged.
- FSM:
  - IDLE: on req_valid_i && req_ready_o, latch remaining=K and next=base (0 becomes 1), then go to PLAN. If K=0, pulse done_o next cycle and stay in IDLE.
  - PLAN: N = min(remaining, MAX_BURST, credit, 2^CNT_W-1 - next + 1). If N=0, stay in PLAN.
  - ISSUE: run_o=1 for exactly one cycle with cnt_start_o=next and cnt_end_o=next+N-1. Then remaining -= N, next = next+N; if next wraps to 0, next becomes 1 (0 is never issued). Load gap counter = N+1.
  - GAP: decrement each cycle. At 0, go to PLAN if remaining>0, else DRAIN.
  - DRAIN: wait until outstanding=0 and delivered=K. Pulse done_o in the same cycle as the final pop, then return to IDLE.
  - cnt_start_o and cnt_end_o hold their last values outside ISSUE.
- FIFO:
  - Push on dvld_i when not full. Pop on tri_valid_o && tri_ready_i.
  - Push and pop in the same cycle are both allowed, including when full.
  - tri_* outputs show the head combinationally from registered storage, with zero-bubble back-to-back pops.
- Overflow: a dvld_i beat while full and not popping is dropped; err_ovf_o sets and holds until reset. Correct credit accounting makes this unreachable, so it flags a protocol error.
- Delivered counter: counts pops within the current request; used by DRAIN and done_o.

Test Plan:
- K=5, base=10, tri_ready_i=1: single run_o with start=10, end=14. Five triples pop in counter order, done_o pulses on the 5th pop, req_ready_o returns high.
- K=100, MAX_BURST=32, DEPTH=64, ready=1: runs at (1,32), (33,64), (65,96), (97,100). Consecutive runs are separated by at least N+1 cycles; no err_ovf_o.
- K=200, tri_ready_i=0 for 500 cycles then 1: at most 64 triples requested before stall (run_o stops). Total delivered is 200, err_ovf_o=0, ordering preserved.
- Wrap, CNT_W=8, base=250, K=10: runs (250,255) then (1,4). Counter 0 never appears on cnt_start_o or cnt_end_o.
- Injected extra dvld_i with FIFO full: err_ovf_o rises and stays set; FIFO contents unchanged.
- Async reset asserted mid-burst: all outputs reach reset values immediately. A fresh K=3 request after release completes with done_o.
